// File: rtl/fir_coef_apply_if.sv
// fir_coef_apply_if: stream bundle for fir_coef_apply.
//   coef_*  : coefficient word stream (valid/ready, last marks final word)
//   x_*     : input sample stream (valid/ready)
//   y_*     : result strobe with full-precision and scaled results
// The master modport belongs to the producer/consumer side; the slave
// modport belongs to the filter.
`timescale 1ns/1ps
interface fir_coef_apply_if #(
  parameter int W1 = 14,
  parameter int WC = 16,
  parameter int W2 = 36
);
  logic                 coef_valid;
  logic signed [WC-1:0] coef_data;
  logic                 coef_last;
  logic                 coef_ready;

  logic                 x_valid;
  logic signed [W1-1:0] x_in;
  logic                 x_ready;

  logic                 y_valid;
  logic signed [W2-1:0] y_out_36;
  logic signed [W1-1:0] y_out_14;

  modport master (
    output coef_valid, coef_data, coef_last, x_valid, x_in,
    input  coef_ready, x_ready, y_valid, y_out_36, y_out_14
  );

  modport slave (
    input  coef_valid, coef_data, coef_last, x_valid, x_in,
    output coef_ready, x_ready, y_valid, y_out_36, y_out_14
  );
endinterface

// File: rtl/fir_coef_apply.sv
// fir_coef_apply: time-multiplexed FIR that applies coefficient sets
// streamed from the adaptive LMS filter to a second signal path.
// Coefficients fill a shadow bank; a complete set is swapped into the
// active bank between samples. One MAC computes each output over L cycles.
// Ports:
//   clk       clock
//   reset_n   asynchronous active-low reset
//   bus       fir_coef_apply_if.slave (coef stream, sample stream, results)
//   coef_err  one-cycle pulse when a coefficient set is malformed
//   bank_sel  index of the active coefficient bank
//   busy      high while a sample is being computed (MAC and OUT)
`timescale 1ns/1ps
module fir_coef_apply #(
  parameter int W1        = 14,
  parameter int WC        = 16,
  parameter int W2        = 36,
  parameter int L         = 33,
  parameter int SHIFT     = 18,
  parameter int ROUND     = 8192,
  parameter int COEF_INIT = 70
) (
  input  logic              clk,
  input  logic              reset_n,
  fir_coef_apply_if.slave   bus,
  output logic              coef_err,
  output logic              bank_sel,
  output logic              busy
);

  localparam int            KW       = (L > 1) ? $clog2(L) : 1;
  localparam logic [KW-1:0] LAST_IDX = KW'(L - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t state, state_nxt;

  logic signed [W1-1:0] dly  [L];
  logic signed [WC-1:0] bank [2][L];
  logic [KW-1:0]        idx;
  logic                 swap_pending;

  logic [KW-1:0]        k_p0;
  logic signed [W2-1:0] acc_p0;

  logic signed [W2-1:0] y36_p1;
  logic signed [W1-1:0] y14_p1;
  logic                 vld_p1;

  logic coef_accept, set_done, set_bad, x_accept, do_swap, x_ready_c;

  // Signed product widened to the accumulator width. Both operands are
  // sign-extended first so the truncated W2-bit product is exact.
  function automatic logic signed [W2-1:0] mac_term(
    input logic signed [W1-1:0] x,
    input logic signed [WC-1:0] c
  );
    logic signed [W2-1:0] xe;
    logic signed [W2-1:0] ce;
    xe = W2'(x);
    ce = W2'(c);
    return xe * ce;
  endfunction

  // Round-half-up then arithmetic shift; result truncated, never saturated.
  function automatic logic signed [W1-1:0] round_shift(
    input logic signed [W2-1:0] a
  );
    logic signed [W2-1:0] t;
    t = a + W2'(ROUND);
    t = t >>> SHIFT;
    return t[W1-1:0];
  endfunction

  assign bus.coef_ready = !swap_pending;
  assign coef_accept    = bus.coef_valid && !swap_pending;
  // A set is well formed only when the last flag and the final index line up.
  assign set_done       = coef_accept && bus.coef_last && (idx == LAST_IDX);
  assign set_bad        = coef_accept && (bus.coef_last != (idx == LAST_IDX));

  // Swapping consumes one IDLE cycle; no sample is taken during it so the
  // active bank is stable for the whole of every MAC pass.
  assign do_swap        = (state == S_IDLE) && swap_pending;
  assign x_ready_c      = (state == S_IDLE) && !swap_pending;
  assign x_accept       = bus.x_valid && x_ready_c;
  assign bus.x_ready    = x_ready_c;
  assign busy           = (state == S_MAC) || (state == S_OUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (x_accept) state_nxt = S_MAC;
      S_MAC:   if (k_p0 == LAST_IDX) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Coefficient loader and bank control. Writes always target the shadow
  // bank; a discarded set may leave it partially written, but only a
  // complete set ever raises swap_pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      swap_pending <= 1'b0;
      coef_err     <= 1'b0;
      bank_sel     <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < L; i++) begin
          bank[b][i] <= WC'(COEF_INIT);
        end
      end
    end else begin
      coef_err <= set_bad;
      if (coef_accept) begin
        bank[~bank_sel][idx] <= bus.coef_data;
        if (set_done || set_bad) begin
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (set_done) begin
        swap_pending <= 1'b1;
      end else if (do_swap) begin
        swap_pending <= 1'b0;
      end
      if (do_swap) begin
        bank_sel <= ~bank_sel;
      end
    end
  end

  // ---- stage p0: delay line and serial MAC ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_p0   <= '0;
      acc_p0 <= '0;
      for (int i = 0; i < L; i++) begin
        dly[i] <= '0;
      end
    end else if (x_accept) begin
      dly[0] <= bus.x_in;
      for (int i = 1; i < L; i++) begin
        dly[i] <= dly[i-1];
      end
      acc_p0 <= '0;
      k_p0   <= '0;
    end else if (state == S_MAC) begin
      acc_p0 <= acc_p0 + mac_term(dly[k_p0], bank[bank_sel][k_p0]);
      k_p0   <= k_p0 + 1'b1;
    end
  end

  // ---- stage p1: result registers, updated only in OUT ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      y36_p1 <= '0;
      y14_p1 <= '0;
    end else begin
      vld_p1 <= (state == S_OUT);
      if (state == S_OUT) begin
        y36_p1 <= acc_p0;
        y14_p1 <= round_shift(acc_p0);
      end
    end
  end

  assign bus.y_valid  = vld_p1;
  assign bus.y_out_36 = y36_p1;
  assign bus.y_out_14 = y14_p1;

endmodule

// File: tb/tb_fir_coef_apply.sv
// tb_fir_coef_apply: directed bench for fir_coef_apply.
// A signed 14-bit sample cannot hold +8192, so the positive impulse uses
// 8191 (largest positive sample): 8191*70 = 573370, scaled result 2.
`timescale 1ns/1ps
module tb_fir_coef_apply;
  localparam int W1 = 14;
  localparam int WC = 16;
  localparam int W2 = 36;
  localparam int L  = 33;

  logic clk;
  logic reset_n;
  logic coef_err;
  logic bank_sel;
  logic busy;

  fir_coef_apply_if #(.W1(W1), .WC(WC), .W2(W2)) bus ();

  fir_coef_apply #(
    .W1(W1), .WC(WC), .W2(W2), .L(L),
    .SHIFT(18), .ROUND(8192), .COEF_INIT(70)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .coef_err (coef_err),
    .bank_sel (bank_sel),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic signed [WC-1:0] cset [L];

  typedef struct {
    int     x;
    integer e36;
    integer e14;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string name, input integer act, input integer exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_coefs(input int v);
    for (int i = 0; i < L; i++) cset[i] = WC'(v);
  endtask

  // Streams words 0..n-1 of cset; coef_last on word last_pos (-1 = never).
  task automatic load_set(input int n, input int last_pos);
    int w;
    for (int i = 0; i < n; i++) begin
      bus.coef_valid = 1'b1;
      bus.coef_data  = cset[i];
      bus.coef_last  = (i == last_pos);
      w = 0;
      while (!bus.coef_ready && w < 200) begin
        cyc();
        w++;
      end
      if (!bus.coef_ready) begin
        n_checks++;
        n_err++;
        $display("FAIL load_ready: got 0 expected 1");
      end
      cyc();
    end
    bus.coef_valid = 1'b0;
    bus.coef_last  = 1'b0;
  endtask

  // Returns at the cycle y_valid is seen; lat counts edges from accept.
  task automatic send_sample(input int xv, output integer y36, output integer y14,
                             output int lat);
    int w;
    w = 0;
    while (!bus.x_ready && w < 200) begin
      cyc();
      w++;
    end
    if (!bus.x_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL x_ready_wait: got 0 expected 1");
    end
    bus.x_valid = 1'b1;
    bus.x_in    = W1'(xv);
    cyc();
    bus.x_valid = 1'b0;
    lat = 0;
    while (!bus.y_valid && lat < 200) begin
      cyc();
      lat++;
    end
    y36 = 32'(bus.y_out_36);
    y14 = 32'(bus.y_out_14);
  endtask

  task automatic sample_chk(input string name, input int xv, input integer e36,
                            input integer e14);
    integer y36, y14;
    int lat;
    send_sample(xv, y36, y14, lat);
    chk({name, "_lat"}, lat, L + 1);
    chk({name, "_y36"}, y36, e36);
    chk({name, "_y14"}, y14, e14);
  endtask

  task automatic run_impulse(input string tag);
    sample_chk({tag, "_imp0"}, 8191, 573370, 2);
    for (int i = 1; i <= L; i++) begin
      sample_chk($sformatf("%s_imp%0d", tag, i), 0,
                 (i < L) ? 573370 : 0, (i < L) ? 2 : 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    integer y36, y14;
    int lat, nv;

    // c[5] = 4096: result n equals 4096 * x[n-5]
    tv[0]  = '{8000, 0, 0};
    tv[1]  = '{0, 0, 0};
    tv[2]  = '{0, 0, 0};
    tv[3]  = '{0, 0, 0};
    tv[4]  = '{0, 0, 0};
    tv[5]  = '{0, 32768000, 125};
    tv[6]  = '{-8000, 0, 0};
    tv[7]  = '{0, 0, 0};
    tv[8]  = '{0, 0, 0};
    tv[9]  = '{0, 0, 0};
    tv[10] = '{0, 0, 0};
    tv[11] = '{0, -32768000, -125};

    reset_n        = 1'b0;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    bus.coef_last  = 1'b0;
    bus.x_valid    = 1'b0;
    bus.x_in       = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    cyc();

    chk("rst_y36", 32'(bus.y_out_36), 0);
    chk("rst_y14", 32'(bus.y_out_14), 0);
    chk("rst_yvalid", 32'(bus.y_valid), 0);
    chk("rst_coef_err", 32'(coef_err), 0);
    chk("rst_bank_sel", 32'(bank_sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_x_ready", 32'(bus.x_ready), 1);
    chk("rst_coef_ready", 32'(bus.coef_ready), 1);

    // Impulse through the reset coefficients
    run_impulse("t1");

    // Single-tap set, table-driven samples
    fill_coefs(0);
    cset[5] = 16'sd4096;
    load_set(L, L - 1);
    cyc();
    cyc();
    chk("t2_bank_sel", 32'(bank_sel), 1);
    for (int i = 0; i < 12; i++) begin
      sample_chk($sformatf("t2_v%0d", i), tv[i].x, tv[i].e36, tv[i].e14);
    end

    // Back to all-70 and flush the delay line with zeros
    fill_coefs(70);
    load_set(L, L - 1);
    cyc();
    cyc();
    chk("flush_bank_sel", 32'(bank_sel), 0);
    for (int i = 0; i < L; i++) send_sample(0, y36, y14, lat);

    // Load during MAC: in-flight sample keeps the old bank
    fill_coefs(2);
    fork
      sample_chk("t3_old", 8191, 573370, 2);
      begin
        nv = 0;
        while (!busy && nv < 50) begin
          cyc();
          nv++;
        end
        load_set(L, L - 1);
      end
    join
    chk("t3_swap_x_ready", 32'(bus.x_ready), 0);
    chk("t3_bank_before", 32'(bank_sel), 0);
    cyc();
    chk("t3_bank_after", 32'(bank_sel), 1);
    chk("t3_x_ready_after", 32'(bus.x_ready), 1);
    sample_chk("t3_new", 0, 16382, 0);

    // Malformed sets are discarded
    fill_coefs(5);
    load_set(11, 10);
    chk("t4_err_early_last", 32'(coef_err), 1);
    cyc();
    chk("t4_err_pulse_end", 32'(coef_err), 0);
    chk("t4_bank_keep", 32'(bank_sel), 1);
    chk("t4_y36_keep", 32'(bus.y_out_36), 16382);
    chk("t4_coef_ready", 32'(bus.coef_ready), 1);
    load_set(L, -1);
    chk("t4_err_no_last", 32'(coef_err), 1);
    cyc();
    cyc();
    chk("t4_bank_keep2", 32'(bank_sel), 1);
    fill_coefs(-1);
    load_set(L, L - 1);
    chk("t4_good_no_err", 32'(coef_err), 0);
    cyc();
    cyc();
    chk("t4_bank_swap", 32'(bank_sel), 0);

    // All -1 coefficients with constant -8192 input
    for (int i = 0; i < 40; i++) begin
      send_sample(-8192, y36, y14, lat);
      chk($sformatf("t5_lat%0d", i), lat, L + 1);
      if (i >= L - 1) begin
        chk($sformatf("t5_y36_%0d", i), y36, 270336);
        chk($sformatf("t5_y14_%0d", i), y14, 1);
      end
    end

    // Reset in the middle of a MAC pass
    fill_coefs(3);
    load_set(L, L - 1);
    cyc();
    cyc();
    chk("t6_bank_pre", 32'(bank_sel), 1);
    bus.x_valid = 1'b1;
    bus.x_in    = W1'(8191);
    cyc();
    bus.x_valid = 1'b0;
    chk("t6_busy", 32'(busy), 1);
    repeat (10) cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_y36_zero", 32'(bus.y_out_36), 0);
    chk("t6_y14_zero", 32'(bus.y_out_14), 0);
    chk("t6_yvalid", 32'(bus.y_valid), 0);
    chk("t6_bank_zero", 32'(bank_sel), 0);
    chk("t6_busy_zero", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.y_valid) nv++;
      cyc();
    end
    chk("t6_no_yvalid", nv, 0);
    chk("t6_bank_post", 32'(bank_sel), 0);
    run_impulse("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
